// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the multi-cycle ALU: op codes, FSM states,
// counter sizing and the signed-overflow rule used by add/sub.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // Carry into the MSB recovered from the operand and sum MSBs, XORed with carry out.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb, input logic carry_out);
    return (a_msb ^ b_msb ^ sum_msb) ^ carry_out;
  endfunction

endpackage

// File: rtl/seq_alu_step.sv
// One iteration of shift-add multiply or restoring divide. Purely combinational;
// partial is the accumulator/remainder, shifter the multiplier/quotient.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] partial,
  input  logic [WIDTH-1:0] shifter,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_partial,
  output logic [WIDTH-1:0] next_shifter
);

  logic [WIDTH:0] mul_sum_s;
  logic [WIDTH:0] div_rem_s;

  // Single multiply or divide step selected by the latched op.
  always_comb begin
    next_partial = partial;
    next_shifter = shifter;
    mul_sum_s    = {1'b0, partial} + {1'b0, operand};
    div_rem_s    = {partial, shifter[WIDTH-1]};
    case (op)
      OP_MUL: begin
        if (shifter[0]) begin
          next_partial = mul_sum_s[WIDTH:1];
          next_shifter = {mul_sum_s[0], shifter[WIDTH-1:1]};
        end else begin
          next_partial = {1'b0, partial[WIDTH-1:1]};
          next_shifter = {partial[0], shifter[WIDTH-1:1]};
        end
      end
      OP_DIV: begin
        // The remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
        if (div_rem_s >= {1'b0, operand}) begin
          next_partial = div_rem_s[WIDTH-1:0] - operand;
          next_shifter = {shifter[WIDTH-2:0], 1'b1};
        end else begin
          next_partial = div_rem_s[WIDTH-1:0];
          next_shifter = {shifter[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        next_partial = partial;
        next_shifter = shifter;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, iterative unsigned mul/div with a
// start/busy/done handshake. Results hold until the next done pulse.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             ov
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic             ov_q, ov_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] addend_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] step_partial_s;
  logic [WIDTH-1:0] step_shifter_s;

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .op           (op_q),
    .partial      (partial_q),
    .shifter      (shifter_q),
    .operand      (operand_q),
    .next_partial (step_partial_s),
    .next_shifter (step_shifter_s)
  );

  // Shared add/sub adder: subtraction is a + ~b + 1.
  always_comb begin
    if (sel == OP_SUB) begin
      addend_s = ~b;
    end else begin
      addend_s = b;
    end
    sum_s = {1'b0, a} + {1'b0, addend_s} + {{WIDTH{1'b0}}, (sel == OP_SUB)};
  end

  // FSM next state, iteration datapath and result capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    operand_d = operand_q;
    partial_d = partial_q;
    shifter_d = shifter_q;
    out_d     = out_q;
    out_hi_d  = out_hi_q;
    ov_d      = ov_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (sel)
            OP_ADD: begin
              op_d     = OP_ADD;
              out_d    = sum_s[WIDTH-1:0];
              out_hi_d = '0;
              ov_d     = sum_s[WIDTH];
              done_d   = 1'b1;
            end
            OP_SUB: begin
              op_d     = OP_SUB;
              out_d    = sum_s[WIDTH-1:0];
              out_hi_d = '0;
              ov_d     = signed_ovf(a[WIDTH-1], addend_s[WIDTH-1], sum_s[WIDTH-1], sum_s[WIDTH]);
              done_d   = 1'b1;
            end
            OP_MUL: begin
              op_d      = OP_MUL;
              state_d   = RUN;
              count_d   = '0;
              operand_d = a;
              partial_d = '0;
              shifter_d = b;
            end
            OP_DIV: begin
              op_d = OP_DIV;
              if (b == '0) begin
                out_d    = '1;
                out_hi_d = a;
                ov_d     = 1'b1;
                done_d   = 1'b1;
              end else begin
                state_d   = RUN;
                count_d   = '0;
                operand_d = b;
                partial_d = '0;
                shifter_d = a;
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        partial_d = step_partial_s;
        shifter_d = step_shifter_s;
        count_d   = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          out_d    = step_shifter_s;
          out_hi_d = step_partial_s;
          if (op_q == OP_MUL) begin
            ov_d = (step_partial_s != '0);
          end else begin
            ov_d = 1'b0;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      count_q   <= '0;
      operand_q <= '0;
      partial_q <= '0;
      shifter_q <= '0;
      out_q     <= '0;
      out_hi_q  <= '0;
      ov_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      operand_q <= operand_d;
      partial_q <= partial_d;
      shifter_q <= shifter_d;
      out_q     <= out_d;
      out_hi_q  <= out_hi_d;
      ov_q      <= ov_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign out_hi = out_hi_q;
  assign ov     = ov_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=16 and WIDTH=8: directed vector table,
// random ops against an arithmetic model, and handshake/reset sequences.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start16, start8;
  logic [1:0]  sel16, sel8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic        busy16, done16, ov16;
  logic        busy8, done8, ov8;
  logic [15:0] out16, hi16;
  logic [7:0]  out8, hi8;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sel(sel16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .out(out16), .out_hi(hi16), .ov(ov16)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sel(sel8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .out(out8), .out_hi(hi8), .ov(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [15:0] exp_hi;
    logic        exp_ov;
    int          exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  task automatic model(input int w, input logic [1:0] s, input logic [63:0] ia, input logic [63:0] ib,
                       output logic [63:0] o, output logic [63:0] h, output logic ov, output int lat);
    longint sa, sb, d, lim;
    logic [63:0] m, p;
    m   = (64'd1 << w) - 64'd1;
    lim = longint'(64'd1 << (w - 1));
    h   = 64'd0;
    ov  = 1'b0;
    lat = 1;
    case (s)
      2'd0: begin
        p  = ia + ib;
        o  = p & m;
        ov = (p > m);
      end
      2'd1: begin
        sa = (ia >= 64'(lim)) ? longint'(ia) - 2 * lim : longint'(ia);
        sb = (ib >= 64'(lim)) ? longint'(ib) - 2 * lim : longint'(ib);
        d  = sa - sb;
        o  = (ia + (m + 64'd1) - ib) & m;
        ov = (d < -lim) || (d > lim - 1);
      end
      2'd2: begin
        p   = ia * ib;
        o   = p & m;
        h   = p >> w;
        ov  = (h != 64'd0);
        lat = w + 1;
      end
      default: begin
        if (ib == 64'd0) begin
          o  = m;
          h  = ia;
          ov = 1'b1;
        end else begin
          o   = ia / ib;
          h   = ia % ib;
          lat = w + 1;
        end
      end
    endcase
  endtask

  task automatic run16(input logic [1:0] s, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] eo, input logic [15:0] eh, input logic ev,
                       input int el, input string nm);
    bit got = 0;
    bit berr = 0;
    @(negedge clk);
    start16 = 1'b1; sel16 = s; a16 = ia; b16 = ib;
    @(posedge clk);
    #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sel16 = 2'($urandom);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (done16) begin
        got = 1;
        if (busy16) berr = 1;
        check({nm, ".latency"}, 64'(k), 64'(el));
        check({nm, ".out"}, 64'(out16), 64'(eo));
        check({nm, ".out_hi"}, 64'(hi16), 64'(eh));
        check({nm, ".ov"}, 64'(ov16), 64'(ev));
      end else if (busy16 !== (el > 1)) begin
        berr = 1;
      end
    end
    check({nm, ".done_seen"}, 64'(got), 64'd1);
    check({nm, ".busy"}, 64'(berr), 64'd0);
  endtask

  task automatic run8(input logic [1:0] s, input logic [7:0] ia, input logic [7:0] ib, input string nm);
    logic [63:0] eo, eh;
    logic ev;
    int el;
    bit got = 0;
    model(8, s, 64'(ia), 64'(ib), eo, eh, ev, el);
    @(negedge clk);
    start8 = 1'b1; sel8 = s; a8 = ia; b8 = ib;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (done8) begin
        got = 1;
        check({nm, ".latency"}, 64'(k), 64'(el));
        check({nm, ".out"}, 64'(out8), eo);
        check({nm, ".out_hi"}, 64'(hi8), eh);
        check({nm, ".ov"}, 64'(ov8), 64'(ev));
      end
    end
    check({nm, ".done_seen"}, 64'(got), 64'd1);
  endtask

  vec_t vecs[12];

  initial begin
    logic [63:0] eo, eh;
    logic ev;
    int el;
    logic [1:0] rs;
    logic [15:0] ra, rb;
    bit seen;

    vecs[0]  = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[1]  = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1};
    vecs[2]  = '{2'd1, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b0, 1};
    vecs[3]  = '{2'd2, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1, 17};
    vecs[4]  = '{2'd2, 16'h00FF, 16'h0003, 16'h02FD, 16'h0000, 1'b0, 17};
    vecs[5]  = '{2'd3, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
    vecs[6]  = '{2'd3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[7]  = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1};
    vecs[8]  = '{2'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 17};
    vecs[9]  = '{2'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};
    vecs[10] = '{2'd3, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 17};
    vecs[11] = '{2'd1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1};

    rst = 1'b1;
    start16 = 1'b0; sel16 = 2'd0; a16 = 16'd0; b16 = 16'd0;
    start8 = 1'b0;  sel8 = 2'd0;  a8 = 8'd0;   b8 = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 64'(busy16), 64'd0);
    check("reset.done", 64'(done16), 64'd0);
    check("reset.out", 64'(out16), 64'd0);
    check("reset.out_hi", 64'(hi16), 64'd0);
    check("reset.ov", 64'(ov16), 64'd0);
    check("reset8.out", 64'(out8), 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run16(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_hi,
            vecs[i].exp_ov, vecs[i].exp_lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rs = 2'($urandom_range(3, 0));
      ra = 16'($urandom);
      case ($urandom_range(3, 0))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(15, 1));
        default: rb = 16'($urandom);
      endcase
      model(16, rs, 64'(ra), 64'(rb), eo, eh, ev, el);
      run16(rs, ra, rb, 16'(eo), 16'(eh), ev, el, $sformatf("rnd%0d", i));
    end

    // mul 3*5 with a stray add start in cycle 4: ignored.
    @(negedge clk);
    start16 = 1'b1; sel16 = 2'd2; a16 = 16'd3; b16 = 16'd5;
    @(posedge clk);
    #1 start16 = 1'b0;
    el = 0;
    for (int k = 1; k <= 40 && el == 0; k++) begin
      @(negedge clk);
      if (k == 4) begin
        start16 = 1'b1; sel16 = 2'd0; a16 = 16'd1; b16 = 16'd1;
      end else begin
        start16 = 1'b0;
      end
      if (done16) begin
        el = k;
        check("restart.out", 64'(out16), 64'd15);
      end
    end
    start16 = 1'b0;
    check("restart.latency", 64'(el), 64'd17);

    // Reset in cycle 6 of a divide abandons it.
    @(negedge clk);
    start16 = 1'b1; sel16 = 2'd3; a16 = 16'h1234; b16 = 16'h0007;
    @(posedge clk);
    #1 start16 = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 64'(busy16), 64'd0);
    check("abort.done", 64'(done16), 64'd0);
    check("abort.out", 64'(out16), 64'd0);
    check("abort.out_hi", 64'(hi16), 64'd0);
    check("abort.ov", 64'(ov16), 64'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done16 || busy16) seen = 1;
    end
    check("abort.no_done", 64'(seen), 64'd0);

    // Add issued in the done cycle of a multiply.
    @(negedge clk);
    start16 = 1'b1; sel16 = 2'd2; a16 = 16'd2; b16 = 16'd3;
    @(posedge clk);
    #1 start16 = 1'b0;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (done16) seen = 1;
    end
    check("b2b.mul_done", 64'(seen), 64'd1);
    check("b2b.mul_out", 64'(out16), 64'd6);
    start16 = 1'b1; sel16 = 2'd0; a16 = 16'd10; b16 = 16'd20;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    check("b2b.add_done", 64'(done16), 64'd1);
    check("b2b.add_out", 64'(out16), 64'd30);
    @(negedge clk);
    check("b2b.done_low", 64'(done16), 64'd0);

    run8(2'd2, 8'h0F, 8'h11, "w8.mul");
    run8(2'd3, 8'hFF, 8'h10, "w8.div");
    run8(2'd3, 8'h42, 8'h00, "w8.div0");
    for (int i = 0; i < 8; i++)
      run8(2'($urandom_range(3, 0)), 8'($urandom), 8'($urandom_range(255, 1)), $sformatf("w8.rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
